bp_be_dcache_replay_fifo: RTL and testbench



---
 rtl/bp_be_dcache_replay_fifo.sv | 126 ++++++++++++
 tb/tb_bp_be_dcache_replay_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_replay_fifo.sv
// rtl/bp_be_dcache_replay_fifo.sv - in-order D$ replay queue with commit/rollback, flush and livelock flag
module bp_be_dcache_replay_fifo #(
    parameter int width_p          = 64,
    parameter int els_p            = 8,
    parameter int commit_latency_p = 2,
    parameter int replay_limit_p   = 15
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  clr_i,
    input  logic [width_p-1:0]                    data_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    output logic [width_p-1:0]                    data_o,
    output logic                                  v_o,
    input  logic                                  yumi_i,
    input  logic                                  commit_v_i,
    output logic                                  poison_o,
    output logic [$clog2(els_p+1)-1:0]            count_o,
    output logic [$clog2(replay_limit_p+1)-1:0]   replay_cnt_o,
    output logic                                  stuck_o
);

    localparam int addr_w = $clog2(els_p);
    localparam int ptr_w  = addr_w + 1;
    localparam int cnt_w  = $clog2(els_p + 1);
    localparam int rc_w   = $clog2(replay_limit_p + 1);
    localparam int lat_w  = commit_latency_p;

    localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);
    localparam logic [ptr_w-1:0] ptr_els = ptr_w'(els_p);
    localparam logic [rc_w-1:0]  rc_one  = rc_w'(1);
    localparam logic [rc_w-1:0]  rc_max  = rc_w'(replay_limit_p);

    // Write, issue and retire pointers; the extra MSB is the wrap bit that
    // separates full from empty when the address bits match.
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   iptr;
    logic [ptr_w-1:0]   rptr;
    logic [width_p-1:0] mem [els_p];
    logic [lat_w-1:0]   infl;
    logic [lat_w-1:0]   infl_next;
    logic [rc_w-1:0]    replay_cnt;
    logic [ptr_w-1:0]   count_full;

    logic enq;
    logic issue;
    logic res;
    logic retire;
    logic rollback;

    assign count_full = wptr - rptr;
    assign count_o    = cnt_w'(count_full);
    assign ready_o    = (count_full != ptr_els);
    assign v_o        = (iptr != wptr);
    assign data_o     = mem[iptr[addr_w-1:0]];

    assign enq      = v_i & ready_o;
    // A yumi with nothing to issue is ignored so the pointers never overtake wptr.
    assign issue    = yumi_i & v_o;
    assign res      = infl[lat_w-1];
    assign retire   = res & commit_v_i & ~clr_i;
    assign rollback = res & ~commit_v_i & ~clr_i;

    assign poison_o     = rollback;
    assign replay_cnt_o = replay_cnt;
    assign stuck_o      = (replay_cnt == rc_max);

    // In-flight marker pipeline: a new issue enters stage 0, older ones shift toward resolve.
    always_comb begin
        infl_next    = '0;
        infl_next[0] = issue;
        for (int i = 1; i < lat_w; i++) begin
            infl_next[i] = infl[i-1];
        end
    end

    // Payload storage; entries are never cleared, only the pointers say what is live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[addr_w-1:0]] <= data_i;
        end
    end

    // Pointer, in-flight and replay-count state; flush beats rollback beats normal flow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr       <= '0;
            iptr       <= '0;
            rptr       <= '0;
            infl       <= '0;
            replay_cnt <= '0;
        end else if (clr_i) begin
            wptr       <= '0;
            iptr       <= '0;
            rptr       <= '0;
            infl       <= '0;
            replay_cnt <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + ptr_one;
            end
            if (rollback) begin
                // Re-issue from the failing (oldest unretired) entry; any issue this
                // cycle is dropped and killed downstream by poison_o.
                iptr <= rptr;
                infl <= '0;
                if (replay_cnt != rc_max) begin
                    replay_cnt <= replay_cnt + rc_one;
                end
            end else begin
                if (issue) begin
                    iptr <= iptr + ptr_one;
                end
                infl <= infl_next;
                if (retire) begin
                    rptr       <= rptr + ptr_one;
                    replay_cnt <= '0;
                end
            end
        end
    end

    illegal_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bp_be_dcache_replay_fifo.sv
// tb/tb_bp_be_dcache_replay_fifo.sv - self-checking bench for bp_be_dcache_replay_fifo
module tb_bp_be_dcache_replay_fifo;

    localparam int W   = 64;
    localparam int ELS = 8;
    localparam int LAT = 2;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic          commit_v_i;
    logic          poison_o;
    logic [3:0]    count_o;
    logic [1:0]    replay_cnt_o;
    logic          stuck_o;

    always #5 clk = ~clk;

    bp_be_dcache_replay_fifo #(
        .width_p(W),
        .els_p(ELS),
        .commit_latency_p(LAT),
        .replay_limit_p(LIM)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .clr_i(clr_i),
        .data_i(data_i),
        .v_i(v_i),
        .ready_o(ready_o),
        .data_o(data_o),
        .v_o(v_o),
        .yumi_i(yumi_i),
        .commit_v_i(commit_v_i),
        .poison_o(poison_o),
        .count_o(count_o),
        .replay_cnt_o(replay_cnt_o),
        .stuck_o(stuck_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: unretired payloads in order, how many of them are issued,
    // the cycle numbers at which each in-flight issue resolves, and the replay count.
    logic [W-1:0] mq[$];
    int           n_iss;
    int           pend[$];
    int           rc;
    int           cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit res_now();
        return (pend.size() > 0) && (pend[0] == cyc);
    endfunction

    task automatic model_clear();
        mq.delete();
        pend.delete();
        n_iss = 0;
        rc    = 0;
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit cm, input bit cl);
        bit exp_v, exp_rdy, iss, res, roll, ret;
        @(negedge clk);
        exp_v   = n_iss < mq.size();
        exp_rdy = mq.size() < ELS;
        iss     = y && exp_v;
        v_i        = v;
        data_i     = d;
        yumi_i     = iss;
        commit_v_i = cm;
        clr_i      = cl;
        #1;
        res  = res_now();
        roll = res && !cm && !cl;
        ret  = res && cm && !cl;
        chk("ready", ready_o, exp_rdy);
        chk("v_o", v_o, exp_v);
        if (exp_v) chk("data_o", data_o, mq[n_iss]);
        chk("count", count_o, mq.size());
        chk("replay_cnt", replay_cnt_o, rc);
        chk("stuck", stuck_o, rc == LIM);
        chk("poison", poison_o, roll);
        @(posedge clk);
        if (cl) begin
            model_clear();
        end else begin
            if (roll) begin
                n_iss = 0;
                pend.delete();
                rc = (rc < LIM) ? rc + 1 : LIM;
            end else begin
                if (ret) begin
                    void'(mq.pop_front());
                    void'(pend.pop_front());
                    n_iss--;
                    rc = 0;
                end
                if (iss) begin
                    n_iss++;
                    pend.push_back(cyc + LAT);
                end
            end
            if (v && exp_rdy) mq.push_back(d);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_v_o", v_o, 0);
        chk("rst_poison", poison_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_replay", replay_cnt_o, 0);
        chk("rst_stuck", stuck_o, 0);
        model_clear();
        v_i = 0; yumi_i = 0; commit_v_i = 0; clr_i = 0; data_i = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit r;
        int fails;
        reset_n = 1'b0; v_i = 0; data_i = '0; yumi_i = 0; commit_v_i = 0; clr_i = 0;
        cyc = 0;
        model_clear();
        #1;
        chk("init_ready", ready_o, 1);
        chk("init_v_o", v_o, 0);
        chk("init_poison", poison_o, 0);
        chk("init_count", count_o, 0);
        chk("init_replay", replay_cnt_o, 0);
        chk("init_stuck", stuck_o, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming A..D with a commit at every resolve.
        for (int i = 0; i < 4; i++) step(1, 64'hA0 + i, 1, 1, 0);
        repeat (6) step(0, '0, 1, 1, 0);
        #1 chk("stream_count", count_o, 0);

        // Rollback when A resolves; C is issued in that same cycle and dropped.
        for (int i = 0; i < 3; i++) step(1, 64'hB0 + i, 0, 1, 0);
        fails = 1;
        for (int k = 0; k < 20 && fails > 0; k++) begin
            r = res_now();
            step(0, '0, 1, !(r && fails > 0), 0);
            if (r && fails > 0) fails--;
        end
        chk("rollback_seen", fails, 0);
        #1;
        chk("rb_replay", replay_cnt_o, 1);
        chk("rb_v_o", v_o, 1);
        chk("rb_data", data_o, 64'hB0);
        chk("rb_count", count_o, 3);
        repeat (10) step(0, '0, 1, 1, 0);
        #1;
        chk("rb_done_count", count_o, 0);
        chk("rb_done_replay", replay_cnt_o, 0);

        // Fill to full, then stream through with wrap.
        for (int i = 0; i < 8; i++) step(1, 64'hC0 + i, 0, 1, 0);
        #1;
        chk("full_ready", ready_o, 0);
        chk("full_count", count_o, 8);
        repeat (40) step(1, 64'hD000 + cyc, 1, 1, 0);
        repeat (14) step(0, '0, 1, 1, 0);
        #1 chk("wrap_count", count_o, 0);

        // Livelock: fail A four times, saturating at the limit, then commit.
        step(1, 64'hE0, 0, 1, 0);
        fails = 4;
        for (int k = 0; k < 40 && fails > 0; k++) begin
            r = res_now();
            step(0, '0, 1, !(r && fails > 0), 0);
            if (r && fails > 0) fails--;
        end
        chk("livelock_fails", fails, 0);
        #1;
        chk("ll_replay", replay_cnt_o, 3);
        chk("ll_stuck", stuck_o, 1);
        repeat (6) step(0, '0, 1, 1, 0);
        #1;
        chk("ll_clr_replay", replay_cnt_o, 0);
        chk("ll_clr_stuck", stuck_o, 0);

        // Flush with 5 entries and 2 in flight, then a late commit.
        for (int i = 0; i < 5; i++) step(1, 64'hF0 + i, 0, 1, 0);
        step(0, '0, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        step(0, '0, 0, 1, 1);
        #1;
        chk("flush_count", count_o, 0);
        chk("flush_v_o", v_o, 0);
        chk("flush_ready", ready_o, 1);
        step(0, '0, 0, 1, 0);
        #1 chk("late_commit_count", count_o, 0);

        // Random traffic, a mid-stream asynchronous reset, then more random traffic.
        repeat (300) step($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        do_reset();
        repeat (200) step($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
